waveform_core: RTL and testbench
================================

# waveform_core

Sample generator stage fed by the divided clock from the clock divider. Each rising edge of the divided clock advances a 256-step phase index and registers one 8-bit sample of the selected waveform: square, sawtooth, triangle or sine. Mode changes take effect only at period boundaries, so the output never glitches mid-period. The samples drive the downstream DAC/PWM output stage.

## Interface
Parameters:
- DUTY, 8'd128, square-wave threshold; output is high while phase < DUTY.
- MIDSCALE, 8'h80, sample value while idle.

Ports:
- clock_in  input  1  system clock (100 MHz); sole clock.
- reset_n  input  1  asynchronous, active-low reset.
- step_clk  input  1  divided clock from the divider; asynchronous to clock_in in use; each rising edge is one sample step.
- enable  input  1  run request; low forces IDLE.
- mode_sel  input  2  0 = square, 1 = sawtooth, 2 = triangle, 3 = sine.
- sample  output  8  current waveform sample, registered.
- sample_valid  output  1  one-cycle pulse in the first cycle a new sample is presented.
- cycle_start  output  1  one-cycle pulse, coincident with sample_valid, when phase 0 is output.
- mode_active  output  2  mode currently generating output.
- phase  output  8  index of the sample currently on `sample`.

## Operation
- step_clk passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3.
  - Each step_clk high level yields exactly one tick, regardless of its width.
- FSM states are IDLE, START and RUN.
  - IDLE: phase = 0, sample = MIDSCALE, mode_active tracks mode_sel every cycle. Moves to START when enable = 1.
  - START: waits for a tick. On the tick: phase <= 0, mode_active <= mode_sel, sample <= f(0, mode_sel), sample_valid = 1, cycle_start = 1, then go to RUN.
  - RUN: on a tick, phase <= phase + 1, wrapping modulo 256.
    - On the wrap 255 -> 0: mode_active <= mode_sel (sampled that cycle) and cycle_start = 1.
    - sample <= f(new phase, new mode_active); sample_valid = 1.
  - From any state, enable = 0 sends the FSM to IDLE on the next edge: phase <= 0, sample <= MIDSCALE, no pulses.
  - enable = 0 wins over a coincident tick.
- Waveform functions, for 8-bit phase p:
  - Square: p < DUTY ? 8'hFF : 8'h00.
  - Sawtooth: p.
  - Triangle: p < 128 ? 2p : 2(255 - p) + 1. Gives 0 at p = 0, 254 at p = 127, 255 at p = 128, 1 at p = 255.
  - Sine: round(128 + 127·sin(2πp/256)). Gives 128 at p = 0, 255 at p = 64, 128 at p = 128, 1 at p = 192.
- All arithmetic is unsigned 8-bit, and no intermediate result exceeds 8 bits.

## Timing
- Latency: step_clk is first sampled high by s1 at edge k. sample, phase and the pulses update at edge k+2, and sample_valid is high from k+2 to k+3.
- Maximum step rate: one tick per 2 clock_in cycles, which requires step_clk high ≥ 1 cycle and low ≥ 1 cycle.
- mode_sel may change at any time. It is ignored in RUN except in the wrap cycle.
- Reset values: sample = MIDSCALE, phase = 0, mode_active = 0, sample_valid = 0, cycle_start = 0, FSM = IDLE, and s1/s2/s3 = 0.
- Asserting reset_n low mid-period returns all outputs to their reset values immediately. The first tick after release and enable takes the START path.

## Configuration
- WAVEFORM_CORE_SINE_EN defined:
  - Mode 3 uses a 64-entry quarter-wave ROM.
  - Indexing uses p[5:0] with mirroring by p[6] and negation about 128 by p[7].
- WAVEFORM_CORE_SINE_EN undefined:
  - No ROM is built, and mode 3 outputs MIDSCALE on every tick.
  - sample_valid, cycle_start, phase and mode_active behave identically in both builds.

## Test plan
- Reset with enable = 1, mode 1, then 256 step_clk pulses → sample sequence 0, 1, …, 255. cycle_start fires only with sample 0. sample_valid count = 256.
- Mode 2, 256 ticks → sample 254 at phase 127, 255 at phase 128, 1 at phase 255. Mode 0 with DUTY = 128 → 128 samples of 8'hFF, then 128 of 8'h00.
- Running mode 1, change mode_sel to 0 at phase 100 → sawtooth continues to 255. The wrap tick outputs 8'hFF with mode_active = 0.
- Drive enable low in the same cycle as a tick at phase 50 → next edge gives phase = 0, sample = 8'h80, no sample_valid. Re-enable and tick → phase 0, cycle_start = 1.
- step_clk held high for 20 cycles → exactly one tick. A rising edge sampled at edge k → sample updates at edge k+2.
- Mode 3 with the macro: phases 0/64/128/192 → 128/255/128/1. Without the macro → 8'h80 with sample_valid still pulsing. reset_n low mid-run → all outputs at their reset values asynchronously.

Source files
------------

// File: rtl/waveform_core.sv
// waveform_core: per-step 8-bit waveform sample generator (square, sawtooth,
// triangle, sine) advanced by a synchronized divided clock. Mode changes land
// only at period wrap so a period is never mixed between waveforms.
// Build option: define WAVEFORM_CORE_SINE_EN to build the quarter-wave sine
// ROM; without it mode 3 emits MIDSCALE on every step.
module waveform_core #(
  parameter logic [7:0] DUTY     = 8'd128,
  parameter logic [7:0] MIDSCALE = 8'h80
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       step_clk,
  input  logic       enable,
  input  logic [1:0] mode_sel,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       cycle_start,
  output logic [1:0] mode_active,
  output logic [7:0] phase
);

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned MODE_W  = 2;
  localparam logic [PHASE_W-1:0] PHASE_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t               state, state_d;
  logic                 s1, s2, s3;
  logic                 tick;
  logic [PHASE_W-1:0]   phase_d;
  logic [PHASE_W-1:0]   sample_d;
  logic [MODE_W-1:0]    mode_d;
  logic                 valid_d;
  logic                 cs_d;

`ifdef WAVEFORM_CORE_SINE_EN
  // Quarter-wave magnitude: round(127*sin(2*pi*i/256)), i = 0..63
  function automatic logic [6:0] sine_quarter(input logic [5:0] i);
    logic [6:0] q;
    case (i)
      6'd0:  q = 7'd0;    6'd1:  q = 7'd3;    6'd2:  q = 7'd6;    6'd3:  q = 7'd9;
      6'd4:  q = 7'd12;   6'd5:  q = 7'd16;   6'd6:  q = 7'd19;   6'd7:  q = 7'd22;
      6'd8:  q = 7'd25;   6'd9:  q = 7'd28;   6'd10: q = 7'd31;   6'd11: q = 7'd34;
      6'd12: q = 7'd37;   6'd13: q = 7'd40;   6'd14: q = 7'd43;   6'd15: q = 7'd46;
      6'd16: q = 7'd49;   6'd17: q = 7'd51;   6'd18: q = 7'd54;   6'd19: q = 7'd57;
      6'd20: q = 7'd60;   6'd21: q = 7'd63;   6'd22: q = 7'd65;   6'd23: q = 7'd68;
      6'd24: q = 7'd71;   6'd25: q = 7'd73;   6'd26: q = 7'd76;   6'd27: q = 7'd78;
      6'd28: q = 7'd81;   6'd29: q = 7'd83;   6'd30: q = 7'd85;   6'd31: q = 7'd88;
      6'd32: q = 7'd90;   6'd33: q = 7'd92;   6'd34: q = 7'd94;   6'd35: q = 7'd96;
      6'd36: q = 7'd98;   6'd37: q = 7'd100;  6'd38: q = 7'd102;  6'd39: q = 7'd104;
      6'd40: q = 7'd106;  6'd41: q = 7'd107;  6'd42: q = 7'd109;  6'd43: q = 7'd111;
      6'd44: q = 7'd112;  6'd45: q = 7'd113;  6'd46: q = 7'd115;  6'd47: q = 7'd116;
      6'd48: q = 7'd117;  6'd49: q = 7'd118;  6'd50: q = 7'd120;  6'd51: q = 7'd121;
      6'd52: q = 7'd122;  6'd53: q = 7'd122;  6'd54: q = 7'd123;  6'd55: q = 7'd124;
      6'd56: q = 7'd125;  6'd57: q = 7'd125;  6'd58: q = 7'd126;  6'd59: q = 7'd126;
      6'd60: q = 7'd126;  6'd61: q = 7'd127;  6'd62: q = 7'd127;  6'd63: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Full sine from the quarter table: p[6] mirrors the index, p[7] negates about 128.
  // The mirrored index is (64 - p[5:0]) so the peak lands exactly on phase 64/192.
  function automatic logic [7:0] sine_value(input logic [7:0] p);
    logic [6:0] mag;
    if (p[6]) begin
      if (p[5:0] == 6'd0) mag = 7'd127;
      else                mag = sine_quarter(6'(6'd0 - p[5:0]));
    end else begin
      mag = sine_quarter(p[5:0]);
    end
    return p[7] ? 8'(8'd128 - {1'b0, mag}) : 8'(8'd128 + {1'b0, mag});
  endfunction
`endif

  // Sample value for phase p in mode m
  function automatic logic [7:0] wave_value(input logic [7:0] p, input logic [1:0] m);
    logic [7:0] v;
    case (m)
      2'd0:    v = (p < DUTY) ? 8'hFF : 8'h00;
      2'd1:    v = p;
      2'd2:    v = p[7] ? {~p[6:0], 1'b1} : {p[6:0], 1'b0};
`ifdef WAVEFORM_CORE_SINE_EN
      default: v = sine_value(p);
`else
      default: v = MIDSCALE;
`endif
    endcase
    return v;
  endfunction

  // Synchronize step_clk and keep one history flop for rising-edge detect
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= step_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // State and registered outputs
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= '0;
      sample       <= MIDSCALE;
      mode_active  <= '0;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else begin
      state        <= state_d;
      phase        <= phase_d;
      sample       <= sample_d;
      mode_active  <= mode_d;
      sample_valid <= valid_d;
      cycle_start  <= cs_d;
    end
  end

  // Next-state and next-output decode; enable low overrides everything
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    sample_d = sample;
    mode_d   = mode_active;
    valid_d  = 1'b0;
    cs_d     = 1'b0;

    case (state)
      IDLE: begin
        phase_d  = '0;
        sample_d = MIDSCALE;
        mode_d   = mode_sel;
        if (enable) state_d = START;
      end
      START: begin
        if (tick) begin
          phase_d  = '0;
          mode_d   = mode_sel;
          sample_d = wave_value(8'd0, mode_sel);
          valid_d  = 1'b1;
          cs_d     = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          phase_d = 8'(phase + 8'd1);
          if (phase == PHASE_MAX) begin
            mode_d = mode_sel;
            cs_d   = 1'b1;
          end
          sample_d = wave_value(phase_d, mode_d);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d  = IDLE;
      phase_d  = '0;
      sample_d = MIDSCALE;
      mode_d   = (state == IDLE) ? mode_sel : mode_active;
      valid_d  = 1'b0;
      cs_d     = 1'b0;
    end
  end

endmodule

// File: tb/tb_waveform_core.sv
// tb_waveform_core: directed checks of waveform_core sweeps, mode switching,
// enable abort, step_clk edge handling, sine points and async reset.
module tb_waveform_core;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b1;
  logic       step_clk = 1'b0;
  logic       enable   = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       cycle_start;
  logic [1:0] mode_active;
  logic [7:0] phase;

  int checks     = 0;
  int failures   = 0;
  int valid_seen = 0;

  waveform_core dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .step_clk     (step_clk),
    .enable       (enable),
    .mode_sel     (mode_sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .cycle_start  (cycle_start),
    .mode_active  (mode_active),
    .phase        (phase)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One step_clk pulse (1 cycle high) from a negedge; returns at the negedge
  // two clocks after the synchronizer first sees it, where the new sample shows.
  task automatic do_step();
    step_clk = 1'b1;
    @(negedge clock_in);
    if (sample_valid) valid_seen++;
    step_clk = 1'b0;
    @(negedge clock_in);
    if (sample_valid) valid_seen++;
    @(negedge clock_in);
    if (sample_valid) valid_seen++;
  endtask

  function automatic int tri_exp(input int p);
    return (p < 128) ? 2 * p : 2 * (255 - p) + 1;
  endfunction

  function automatic int sq_exp(input int p);
    return (p < 128) ? 255 : 0;
  endfunction

  initial begin
    logic [7:0] sin0, sin64, sin128, sin192;
    int cnt;
    int first_idx;
    int ff_count;

`ifdef WAVEFORM_CORE_SINE_EN
    sin0 = 8'd128; sin64 = 8'd255; sin128 = 8'd128; sin192 = 8'd1;
`else
    sin0 = 8'h80;  sin64 = 8'h80;  sin128 = 8'h80;  sin192 = 8'h80;
`endif

    // Reset with enable high, sawtooth selected
    enable   = 1'b1;
    mode_sel = 2'd1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock_in);
    check("rst_sample", 32'(sample), 32'h80);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_mode", 32'(mode_active), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_cs", 32'(cycle_start), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_in);
    check("start_no_valid", 32'(sample_valid), 32'd0);

    // Sawtooth sweep: 256 steps give 0..255, cycle_start only on 0
    valid_seen = 0;
    for (int i = 0; i < 256; i++) begin
      do_step();
      check("saw_sample", 32'(sample), 32'(i));
      check("saw_phase", 32'(phase), 32'(i));
      check("saw_cs", 32'(cycle_start), 32'(i == 0));
    end
    check("saw_valid_count", 32'(valid_seen), 32'd256);
    @(negedge clock_in);
    check("valid_one_cycle", 32'(sample_valid), 32'd0);

    // Triangle sweep, mode picked up at the wrap
    mode_sel = 2'd2;
    for (int i = 0; i < 256; i++) begin
      do_step();
      check("tri_sample", 32'(sample), 32'(tri_exp(i)));
      check("tri_phase", 32'(phase), 32'(i));
      if (i == 0) check("tri_mode", 32'(mode_active), 32'd2);
      if (i == 127) check("tri_127", 32'(sample), 32'd254);
      if (i == 128) check("tri_128", 32'(sample), 32'd255);
      if (i == 255) check("tri_255", 32'(sample), 32'd1);
    end

    // Square sweep with default duty
    mode_sel = 2'd0;
    ff_count = 0;
    for (int i = 0; i < 256; i++) begin
      do_step();
      check("sq_sample", 32'(sample), 32'(sq_exp(i)));
      if (sample == 8'hFF) ff_count++;
    end
    check("sq_ff_count", 32'(ff_count), 32'd128);

    // Mode change mid-period is deferred to the wrap
    mode_sel = 2'd1;
    do_step();
    check("mc_wrap_mode1", 32'(mode_active), 32'd1);
    for (int i = 1; i <= 100; i++) do_step();
    check("mc_phase100", 32'(phase), 32'd100);
    mode_sel = 2'd0;
    for (int i = 101; i < 256; i++) begin
      do_step();
      check("mc_saw_sample", 32'(sample), 32'(i));
      check("mc_saw_mode", 32'(mode_active), 32'd1);
    end
    do_step();
    check("mc_wrap_sample", 32'(sample), 32'hFF);
    check("mc_wrap_mode0", 32'(mode_active), 32'd0);
    check("mc_wrap_cs", 32'(cycle_start), 32'd1);
    check("mc_wrap_phase", 32'(phase), 32'd0);

    // Enable dropped in the same cycle as the tick that would give phase 50
    for (int i = 1; i <= 49; i++) do_step();
    check("en_phase49", 32'(phase), 32'd49);
    step_clk = 1'b1;
    @(negedge clock_in);
    step_clk = 1'b0;
    @(negedge clock_in);
    enable = 1'b0;
    @(negedge clock_in);
    check("en_off_phase", 32'(phase), 32'd0);
    check("en_off_sample", 32'(sample), 32'h80);
    check("en_off_valid", 32'(sample_valid), 32'd0);
    check("en_off_cs", 32'(cycle_start), 32'd0);
    @(negedge clock_in);
    check("en_off_valid2", 32'(sample_valid), 32'd0);
    mode_sel = 2'd1;
    enable   = 1'b1;
    repeat (2) @(negedge clock_in);
    check("reen_idle_mode", 32'(mode_active), 32'd1);
    check("reen_no_valid", 32'(sample_valid), 32'd0);
    do_step();
    check("reen_phase", 32'(phase), 32'd0);
    check("reen_cs", 32'(cycle_start), 32'd1);
    check("reen_valid", 32'(sample_valid), 32'd1);
    check("reen_sample", 32'(sample), 32'd0);

    // step_clk held high for 20 cycles gives exactly one tick, at edge k+2
    step_clk  = 1'b1;
    cnt       = 0;
    first_idx = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clock_in);
      if (sample_valid) begin
        cnt++;
        if (first_idx < 0) first_idx = j;
      end
    end
    step_clk = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock_in);
      if (sample_valid) cnt++;
    end
    check("hold_tick_count", 32'(cnt), 32'd1);
    check("hold_latency", 32'(first_idx), 32'd2);
    check("hold_phase", 32'(phase), 32'd1);
    check("hold_sample", 32'(sample), 32'd1);

    // Sine points (MIDSCALE when the ROM is not built)
    mode_sel = 2'd3;
    for (int i = 2; i <= 256; i++) do_step();
    check("sin_phase0", 32'(phase), 32'd0);
    check("sin_mode", 32'(mode_active), 32'd3);
    check("sin_cs", 32'(cycle_start), 32'd1);
    check("sin_0", 32'(sample), 32'(sin0));
    for (int p = 1; p <= 192; p++) begin
      do_step();
      check("sin_valid", 32'(sample_valid), 32'd1);
      if (p == 64)  check("sin_64", 32'(sample), 32'(sin64));
      if (p == 128) check("sin_128", 32'(sample), 32'(sin128));
      if (p == 192) check("sin_192", 32'(sample), 32'(sin192));
    end

    // Asynchronous reset mid-run, then a fresh START
    @(posedge clock_in);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample), 32'h80);
    check("arst_phase", 32'(phase), 32'd0);
    check("arst_mode", 32'(mode_active), 32'd0);
    check("arst_valid", 32'(sample_valid), 32'd0);
    check("arst_cs", 32'(cycle_start), 32'd0);
    @(negedge clock_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clock_in);
    do_step();
    check("post_rst_phase", 32'(phase), 32'd0);
    check("post_rst_cs", 32'(cycle_start), 32'd1);
    check("post_rst_mode", 32'(mode_active), 32'd3);
    check("post_rst_sample", 32'(sample), 32'(sin0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
